insight_counter_ctrl: RTL and testbench
=======================================

// Module: insight_counter_ctrl
// PURPOSE
// - Controller for per-hart Insight event counters: configures event_sel per slot, accumulates 2-bit inc per cycle.
// - Handles arm/disarm, event-change settle blanking, wrap/overflow and sticky interrupt.
// - Sits between the debug/CSR config port and the NUM_CNT hart counter slots.
// - Serialises config/read commands with a valid/ready command channel and a held read-response channel.
// PARAMETERS
// NUM_CNT   4   number of counter slots
// CNT_W     48  accumulator width per slot
// SEL_W     32  event_sel width
// SETTLE    2   cycles inc is ignored after event_sel write (>=1)
// PORTS
// clock        in   1              sole clock, rising edge
// reset_n      in   1              async assert, active-low; release synchronised upstream
// cmd_valid    in   1              command present
// cmd_ready    out  1              command accepted when valid&ready
// cmd_op       in   3              0 WR_SEL, 1 WR_CNT, 2 ARM, 3 DISARM, 4 RD_CNT, 5 CLR_OVF; others NOP
// cmd_idx      in   $clog2(NUM_CNT) target slot
// cmd_wdata    in   64             WR_SEL uses [SEL_W-1:0], WR_CNT uses [CNT_W-1:0]
// rsp_valid    out  1              read response valid
// rsp_ready    in   1              response consumed
// rsp_data     out  64             zero-extended count
// event_sel    out  NUM_CNT*SEL_W  registered selector per slot to hart counter
// inc          in   NUM_CNT*2      per-slot increment 0..3 this cycle
// freeze       in   1              global halt (e.g. debug mode)
// ovf_en       in   NUM_CNT        per-slot interrupt enable
// ovf          out  NUM_CNT        sticky overflow flags
// irq          out  1              registered |(ovf & ovf_en)
// BEHAVIOUR
// - Reset: event_sel=0, counts=0, armed=0, settle=0, ovf=0, irq=0, rsp_valid=0, rsp_data=0, cmd_ready=1, FSM=IDLE.
// - FSM IDLE: cmd_ready=1; accept -> execute op same edge; RD_CNT -> RESP. RESP: cmd_ready=0, rsp_valid=1, rsp_data stable; rsp_valid&rsp_ready -> IDLE.
// - RD_CNT latency: rsp_valid asserted cycle after accept; returns count as of accept edge (pre-inc of that cycle).
// - WR_SEL: event_sel[idx] updated next cycle; settle[idx]=SETTLE, decrements each cycle; inc[idx] ignored while settle!=0.
// - WR_CNT: count[idx]=wdata; same-cycle inc[idx] dropped (write wins); ovf unchanged.
// - ARM/DISARM: set/clear armed[idx]; DISARM also clears settle[idx]. Count held while disarmed.
// - Count update: count += inc when armed & !freeze & settle==0 & no WR_CNT to slot; CNT_W-bit add.
// - Wrap: carry out of CNT_W -> count wraps modulo 2^CNT_W, ovf[idx] set same edge (sticky).
// - CLR_OVF: clears ovf[idx]; a same-cycle new overflow wins (ovf stays 1).
// - irq registered: reflects ovf/ovf_en one cycle later; drops one cycle after clear.
// - Unknown op / idx>=NUM_CNT: accepted, no state change, no response.
// - freeze affects counting only; commands still execute.
// - Reset mid-RESP: rsp_valid drops immediately (async), pending response discarded.
// STRUCTURE
// - Package insight_counter_pkg: cmd_op_e enum, ctrl_state_e {IDLE,RESP}, CNT_W/SEL_W defaults.
// - Sub-module insight_counter_slot (one per NUM_CNT via generate): event_sel reg, settle down-counter, armed, accumulator, ovf.
// - Top holds command FSM, response register, irq register, slot-index decode.
// TESTING
// - ARM 0, inc[0]=3 for 10 cycles -> RD_CNT 0 returns 30; rsp_data held while rsp_ready=0 for 5 cycles, cmd_ready=0 throughout.
// - WR_SEL 1 =0x12 with inc[1]=1 constant, armed -> first 2 cycles not counted, event_sel[1]=0x12 one cycle after accept.
// - WR_CNT 2 =2^48-2, inc[2]=3, ovf_en[2]=1 -> count=1, ovf[2]=1, irq=1 next cycle; CLR_OVF -> irq=0 one cycle later.
// - WR_CNT 3 =100 same cycle as inc[3]=2 -> count exactly 100; freeze=1 with inc=3 -> count unchanged.
// - DISARM during settle then ARM -> counting resumes without residual blanking; reset_n low while RESP -> rsp_valid=0, cmd_ready=1 on release.
// - Op=7 and idx out of range -> accepted, no response, all state unchanged.

Source files
------------

// File: rtl/insight_counter_pkg.sv
// Shared types and defaults for the Insight event counter controller.
//   cmd_op_e     : command opcodes on the config/read command channel
//   ctrl_state_e : command FSM states (IDLE accepts, RESP holds a read result)
//   *_DEF        : default slot count and field widths
//   idx_width()  : slot-index width, never narrower than one bit
package insight_counter_pkg;

  localparam int NUM_CNT_DEF = 4;
  localparam int CNT_W_DEF   = 48;
  localparam int SEL_W_DEF   = 32;
  localparam int SETTLE_DEF  = 2;
  localparam int DATA_W      = 64;

  typedef enum logic [2:0] {
    OP_WR_SEL  = 3'd0,
    OP_WR_CNT  = 3'd1,
    OP_ARM     = 3'd2,
    OP_DISARM  = 3'd3,
    OP_RD_CNT  = 3'd4,
    OP_CLR_OVF = 3'd5
  } cmd_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } ctrl_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/insight_counter_slot.sv
// One Insight counter slot: event selector register, post-select settle
// blanking, arm state, CNT_W-bit accumulator and sticky overflow flag.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   wr_sel/wr_cnt/arm/disarm/clr_ovf : single-cycle strobes, already
//                               qualified by command accept and slot decode
//   sel_wdata, cnt_wdata      : write data for WR_SEL / WR_CNT
//   inc                       : increment 0..3 for this cycle
//   freeze                    : global counting halt
//   event_sel, count, ovf     : registered slot state
module insight_counter_slot
  import insight_counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_sel,
  input  logic             wr_cnt,
  input  logic             arm,
  input  logic             disarm,
  input  logic             clr_ovf,
  input  logic [SEL_W-1:0] sel_wdata,
  input  logic [CNT_W-1:0] cnt_wdata,
  input  logic [1:0]       inc,
  input  logic             freeze,
  output logic [SEL_W-1:0] event_sel,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int SETTLE_W = $clog2(SETTLE + 1);

  logic [SEL_W-1:0]    event_sel_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic                armed_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                ovf_reg;

  logic                count_en;
  logic [CNT_W:0]      sum;

  // A counter write in the same cycle takes precedence over the increment.
  assign count_en = armed_reg & ~freeze & (settle_reg == '0) & ~wr_cnt;
  // One extra bit catches the carry out of the accumulator.
  assign sum      = {1'b0, count_reg} + {{(CNT_W-1){1'b0}}, inc};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      event_sel_reg <= '0;
      settle_reg    <= '0;
      armed_reg     <= 1'b0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      if (wr_sel) begin
        event_sel_reg <= sel_wdata;
      end

      // Blank the increment while the hart counter switches to the new event;
      // disarming drops any remaining blanking so a later re-arm counts at once.
      if (wr_sel) begin
        settle_reg <= SETTLE_W'(SETTLE);
      end else if (disarm) begin
        settle_reg <= '0;
      end else if (settle_reg != '0) begin
        settle_reg <= settle_reg - SETTLE_W'(1);
      end

      if (arm) begin
        armed_reg <= 1'b1;
      end else if (disarm) begin
        armed_reg <= 1'b0;
      end

      if (wr_cnt) begin
        count_reg <= cnt_wdata;
      end else if (count_en) begin
        count_reg <= sum[CNT_W-1:0];
      end

      // A fresh wrap on the clearing edge keeps the flag set.
      ovf_reg <= (ovf_reg & ~clr_ovf) | (count_en & sum[CNT_W]);
    end
  end

  assign event_sel = event_sel_reg;
  assign count     = count_reg;
  assign ovf       = ovf_reg;

endmodule

// File: rtl/insight_counter_ctrl.sv
// Insight event counter controller: decodes config/read commands arriving on a
// valid/ready channel, drives NUM_CNT counter slots and returns counts on a held
// response channel. Raises a registered interrupt from enabled sticky overflows.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   cmd_valid/cmd_ready            : command handshake (ready only in IDLE)
//   cmd_op, cmd_idx, cmd_wdata     : opcode, target slot, write data
//   rsp_valid/rsp_ready, rsp_data  : read response, held until consumed
//   event_sel                      : per-slot selector to the hart counters
//   inc                            : per-slot 2-bit increment this cycle
//   freeze                         : global counting halt
//   ovf_en, ovf, irq               : overflow enables, sticky flags, interrupt
module insight_counter_ctrl
  import insight_counter_pkg::*;
#(
  parameter  int NUM_CNT = NUM_CNT_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int SEL_W   = SEL_W_DEF,
  parameter  int SETTLE  = SETTLE_DEF,
  localparam int IDX_W   = idx_width(NUM_CNT)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [IDX_W-1:0]         cmd_idx,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [NUM_CNT*SEL_W-1:0] event_sel,
  input  logic [NUM_CNT*2-1:0]     inc,
  input  logic                     freeze,
  input  logic [NUM_CNT-1:0]       ovf_en,
  output logic [NUM_CNT-1:0]       ovf,
  output logic                     irq
);

  ctrl_state_e         state_reg;
  ctrl_state_e         state_next;
  logic                accept;
  logic                op_wr_sel, op_wr_cnt, op_arm, op_disarm, op_rd_cnt, op_clr_ovf;
  logic [NUM_CNT-1:0]  slot_hit;
  logic [CNT_W-1:0]    count_arr [NUM_CNT];
  logic [CNT_W-1:0]    rd_count;
  logic                rd_start;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                irq_reg;
  logic                unused_wdata;

  // Taken from the state register rather than cmd_ready to keep the
  // handshake free of combinational feedback through the FSM block.
  assign accept = cmd_valid & (state_reg == IDLE);

  assign op_wr_sel  = (cmd_op == OP_WR_SEL);
  assign op_wr_cnt  = (cmd_op == OP_WR_CNT);
  assign op_arm     = (cmd_op == OP_ARM);
  assign op_disarm  = (cmd_op == OP_DISARM);
  assign op_rd_cnt  = (cmd_op == OP_RD_CNT);
  assign op_clr_ovf = (cmd_op == OP_CLR_OVF);

  // An index with no matching slot hits nothing, so the command is accepted
  // and dropped without touching any state.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_slot
      assign slot_hit[gi] = accept & (cmd_idx == IDX_W'(gi));

      insight_counter_slot #(
        .CNT_W  (CNT_W),
        .SEL_W  (SEL_W),
        .SETTLE (SETTLE)
      ) u_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_sel    (slot_hit[gi] & op_wr_sel),
        .wr_cnt    (slot_hit[gi] & op_wr_cnt),
        .arm       (slot_hit[gi] & op_arm),
        .disarm    (slot_hit[gi] & op_disarm),
        .clr_ovf   (slot_hit[gi] & op_clr_ovf),
        .sel_wdata (cmd_wdata[SEL_W-1:0]),
        .cnt_wdata (cmd_wdata[CNT_W-1:0]),
        .inc       (inc[gi*2 +: 2]),
        .freeze    (freeze),
        .event_sel (event_sel[gi*SEL_W +: SEL_W]),
        .count     (count_arr[gi]),
        .ovf       (ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (slot_hit[i]) begin
        rd_count = count_arr[i];
      end
    end
  end

  assign rd_start = accept & op_rd_cnt & (|slot_hit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (rd_start) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The response captures the count before this edge's increment lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (rd_start) begin
        rsp_data_reg <= DATA_W'(rd_count);
      end
      irq_reg <= |(ovf & ovf_en);
    end
  end

  assign rsp_data     = rsp_data_reg;
  assign irq          = irq_reg;
  assign unused_wdata = ^cmd_wdata;

endmodule

// File: tb/tb_insight_counter_ctrl.sv
module tb_insight_counter_ctrl;

  localparam int N  = 4;
  localparam int ST = 2;
  localparam longint unsigned TWO48 = 64'h0001_0000_0000_0000;
  localparam logic [2:0] WR_SEL = 3'd0, WR_CNT = 3'd1, ARM = 3'd2,
                         DISARM = 3'd3, RD_CNT = 3'd4, CLR_OVF = 3'd5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_idx;
  logic [63:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [63:0]   rsp_data;
  logic [127:0]  event_sel;
  logic [7:0]    inc;
  logic          freeze;
  logic [3:0]    ovf_en, ovf;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint unsigned m_cnt [N];
  logic [31:0]     m_sel [N];
  bit              m_armed [N];
  int              m_settle [N];
  bit              m_ovf [N];
  bit              m_irq;
  bit              m_pend;
  longint unsigned m_rsp;

  insight_counter_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .event_sel(event_sel), .inc(inc), .freeze(freeze),
    .ovf_en(ovf_en), .ovf(ovf), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_sel[i] = 0; m_armed[i] = 0; m_settle[i] = 0; m_ovf[i] = 0;
    end
    m_irq = 0; m_pend = 0; m_rsp = 0;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit acc, hit, counting, wrap, irq_n;
    int op, ix;
    longint unsigned s;
    acc = cmd_valid && !m_pend;
    op  = int'(cmd_op);
    ix  = int'(cmd_idx);
    irq_n = 0;
    for (int i = 0; i < N; i++) if (m_ovf[i] && ovf_en[i]) irq_n = 1;
    m_irq = irq_n;
    if (!m_pend) begin
      if (acc && op == 4) begin m_pend = 1; m_rsp = m_cnt[ix]; end
    end else if (rsp_ready) begin
      m_pend = 0;
    end
    for (int i = 0; i < N; i++) begin
      hit      = acc && (ix == i);
      counting = m_armed[i] && !freeze && (m_settle[i] == 0);
      wrap     = 0;
      if (hit && op == 1) m_cnt[i] = cmd_wdata & (TWO48 - 1);
      else if (counting) begin
        s = m_cnt[i] + longint'(inc[2*i +: 2]);
        if (s >= TWO48) begin s = s - TWO48; wrap = 1; end
        m_cnt[i] = s;
      end
      if (hit && op == 5) m_ovf[i] = 0;
      if (wrap) m_ovf[i] = 1;
      if (hit && op == 0) begin m_sel[i] = cmd_wdata[31:0]; m_settle[i] = ST; end
      else if (hit && op == 3) m_settle[i] = 0;
      else if (m_settle[i] > 0) m_settle[i]--;
      if (hit && op == 2) m_armed[i] = 1;
      if (hit && op == 3) m_armed[i] = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_cmd(input logic [2:0] op, input int ix, input logic [63:0] wd);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = 2'(ix); cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_idx = 2'd0; cmd_wdata = 64'd0;
  endtask

  task automatic rd(input int ix, output logic [63:0] d);
    do_cmd(RD_CNT, ix, 64'd0);
    d = rsp_data;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (event_sel !== 128'd0) begin failures++; $display("FAIL reset_event_sel got=%h exp=0", event_sel); end
    checks++; if (ovf !== 4'd0 || irq !== 1'b0) begin failures++; $display("FAIL reset_ovf_irq got=%b/%b exp=0/0", ovf, irq); end
    reset_n = 1'b1;
    model_reset();
    tick();
    rd(0, v);
    checks++; if (v !== 64'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", v); end
  endtask

  task automatic test_arm_count();
    do_cmd(ARM, 0, 64'd0);
    inc[1:0] = 2'd3;
    repeat (10) tick();
    inc = 8'd0;
    do_cmd(RD_CNT, 0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_rsp_valid cyc=%0d got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_data !== 64'd30 || rsp_data !== m_rsp) begin failures++; $display("FAIL hold_rsp_data cyc=%0d got=%0d exp=30", k, rsp_data); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hold_cmd_ready cyc=%0d got=%b exp=0", k, cmd_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rsp_release got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_settle();
    logic [63:0] base, v;
    do_cmd(ARM, 1, 64'd0);
    rd(1, base);
    checks++; if (event_sel[63:32] !== 32'd0) begin failures++; $display("FAIL sel_before got=%h exp=0", event_sel[63:32]); end
    do_cmd(WR_SEL, 1, 64'h12);
    checks++; if (event_sel[63:32] !== 32'h12) begin failures++; $display("FAIL sel_after got=%h exp=12", event_sel[63:32]); end
    inc[3:2] = 2'd1;
    repeat (5) tick();
    inc = 8'd0;
    rd(1, v);
    checks++; if (v !== base + 64'd3 || v !== m_cnt[1]) begin failures++; $display("FAIL settle_count got=%0d exp=%0d", v, base + 64'd3); end
  endtask

  task automatic test_wrap();
    logic [63:0] v;
    ovf_en = 4'b0100;
    do_cmd(ARM, 2, 64'd0);
    do_cmd(WR_CNT, 2, TWO48 - 2);
    inc[5:4] = 2'd3;
    tick();
    inc = 8'd0;
    checks++; if (ovf[2] !== 1'b1 || irq !== 1'b0) begin failures++; $display("FAIL wrap_edge got=ovf%b/irq%b exp=1/0", ovf[2], irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL wrap_irq got=%b exp=1", irq); end
    rd(2, v);
    checks++; if (v !== 64'd1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", v); end
    do_cmd(CLR_OVF, 2, 64'd0);
    checks++; if (ovf[2] !== 1'b0 || irq !== 1'b1) begin failures++; $display("FAIL clr_edge got=ovf%b/irq%b exp=0/1", ovf[2], irq); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq got=%b exp=0", irq); end
    do_cmd(WR_CNT, 2, TWO48 - 1);
    inc[5:4] = 2'd1;
    tick();
    inc = 8'd0;
    do_cmd(WR_CNT, 2, TWO48 - 1);
    checks++; if (ovf[2] !== 1'b1) begin failures++; $display("FAIL wrcnt_keeps_ovf got=%b exp=1", ovf[2]); end
    inc[5:4] = 2'd1;
    do_cmd(CLR_OVF, 2, 64'd0);
    inc = 8'd0;
    checks++; if (ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_wins_clr got=%b exp=1", ovf[2]); end
    do_cmd(CLR_OVF, 2, 64'd0);
    checks++; if (ovf[2] !== 1'b0) begin failures++; $display("FAIL clr_plain got=%b exp=0", ovf[2]); end
    ovf_en = 4'b0000;
  endtask

  task automatic test_write_wins();
    logic [63:0] v;
    do_cmd(ARM, 3, 64'd0);
    inc[7:6] = 2'd2;
    do_cmd(WR_CNT, 3, 64'd100);
    inc = 8'd0;
    rd(3, v);
    checks++; if (v !== 64'd100) begin failures++; $display("FAIL write_wins got=%0d exp=100", v); end
    freeze = 1'b1;
    inc[7:6] = 2'd3;
    repeat (5) tick();
    rd(3, v);
    freeze = 1'b0;
    inc = 8'd0;
    checks++; if (v !== 64'd100) begin failures++; $display("FAIL freeze_hold got=%0d exp=100", v); end
  endtask

  task automatic test_disarm_settle();
    logic [63:0] base, v;
    rd(0, base);
    do_cmd(WR_SEL, 0, 64'h55);
    do_cmd(DISARM, 0, 64'd0);
    do_cmd(ARM, 0, 64'd0);
    inc[1:0] = 2'd1;
    repeat (3) tick();
    inc = 8'd0;
    rd(0, v);
    checks++; if (v !== base + 64'd3) begin failures++; $display("FAIL rearm_count got=%0d exp=%0d", v, base + 64'd3); end
    do_cmd(DISARM, 0, 64'd0);
    inc[1:0] = 2'd3;
    repeat (4) tick();
    inc = 8'd0;
    rd(0, v);
    checks++; if (v !== base + 64'd3) begin failures++; $display("FAIL disarm_hold got=%0d exp=%0d", v, base + 64'd3); end
  endtask

  task automatic test_nop();
    longint unsigned pre [N];
    logic [127:0] sel_pre;
    logic [3:0]   ovf_pre;
    logic [63:0]  v;
    for (int i = 0; i < N; i++) pre[i] = m_cnt[i];
    sel_pre = event_sel;
    ovf_pre = ovf;
    do_cmd(3'd7, int'($urandom_range(0, 3)), {$urandom, $urandom});
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL nop7_rsp got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    do_cmd(3'd6, int'($urandom_range(0, 3)), {$urandom, $urandom});
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL nop6_rsp got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    checks++; if (event_sel !== sel_pre || ovf !== ovf_pre) begin failures++; $display("FAIL nop_state got=%h/%b exp=%h/%b", event_sel, ovf, sel_pre, ovf_pre); end
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      checks++; if (v !== pre[i]) begin failures++; $display("FAIL nop_count slot=%0d got=%0d exp=%0d", i, v, pre[i]); end
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [63:0] v;
    do_cmd(RD_CNT, 1, 64'd0);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_rsp got=%b exp=1", rsp_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL async_reset got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    checks++; if (event_sel !== 128'd0 || ovf !== 4'd0) begin failures++; $display("FAIL async_reset_state got=%h/%b exp=0/0", event_sel, ovf); end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset got=%b/%b exp=0/1", rsp_valid, cmd_ready); end
    rd(1, v);
    checks++; if (v !== 64'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=0", v); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   exp_ovf;
    logic [127:0] exp_sel;
    logic [63:0]  v;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_idx   = 2'($urandom_range(0, 3));
      cmd_wdata = ($urandom_range(0, 3) == 0) ? (64'h0000_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                              : {$urandom, $urandom};
      inc       = 8'($urandom);
      freeze    = ($urandom_range(0, 9) == 0);
      ovf_en    = 4'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      checks++; if (cmd_ready !== !m_pend) begin failures++; $display("FAIL rnd_cmd_ready cyc=%0d got=%b exp=%b", c, cmd_ready, !m_pend); end
      tick();
      exp_ovf = '0;
      exp_sel = '0;
      for (int i = 0; i < N; i++) begin
        exp_ovf[i] = m_ovf[i];
        exp_sel[i*32 +: 32] = m_sel[i];
      end
      checks++; if (rsp_valid !== m_pend) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, m_pend); end
      if (m_pend) begin
        checks++; if (rsp_data !== m_rsp) begin failures++; $display("FAIL rnd_rsp_data cyc=%0d got=%0d exp=%0d", c, rsp_data, m_rsp); end
      end
      checks++; if (ovf !== exp_ovf || irq !== m_irq) begin failures++; $display("FAIL rnd_ovf_irq cyc=%0d got=%b/%b exp=%b/%b", c, ovf, irq, exp_ovf, m_irq); end
      checks++; if (event_sel !== exp_sel) begin failures++; $display("FAIL rnd_event_sel cyc=%0d got=%h exp=%h", c, event_sel, exp_sel); end
    end
    cmd_valid = 1'b0; inc = 8'd0; freeze = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      checks++; if (v !== m_cnt[i]) begin failures++; $display("FAIL rnd_final_count slot=%0d got=%0d exp=%0d", i, v, m_cnt[i]); end
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_idx = 2'd0; cmd_wdata = 64'd0;
    rsp_ready = 1'b0; inc = 8'd0; freeze = 1'b0; ovf_en = 4'd0;
    model_reset();
    test_reset();
    test_arm_count();
    test_settle();
    test_wrap();
    test_write_wins();
    test_disarm_settle();
    test_nop();
    test_reset_mid_resp();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
